fibre_tx: RTL and testbench

Serial line transmitter for the fibre link: the transmit-side counterpart of `clock_data_recovery`. Accepts bytes over a valid/ready handshake and emits them on a single NRZ line at one bit per `OVERSAMPLE` cycles of `clk_x8`. Each frame carries:
- an alternating preamble, for receiver CDR lock;
- a sync byte;
- bit-stuffed payload;
- an end-of-frame run.

Idle is an alternating pattern, so the far-end CDR stays locked between frames.

---
 rtl/fibre_link_pkg.sv | 23 ++
 rtl/fibre_bit_timer.sv | 28 ++
 rtl/fibre_tx.sv | 192 +++++++++++++++++++
 tb/tb_fibre_tx.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fibre_link_pkg.sv
// Shared fibre link constants and transmitter state encoding; the CDR deframer must use the same defaults.
package fibre_link_pkg;

    localparam int unsigned DEF_OVERSAMPLE    = 8;
    localparam int unsigned DEF_PREAMBLE_BITS = 16;
    localparam logic [7:0]  DEF_SYNC_BYTE     = 8'hD5;
    localparam int unsigned DEF_MAX_RUN       = 5;
    localparam int unsigned DEF_EOF_BITS      = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_SYNC     = 3'd2,
        ST_DATA     = 3'd3,
        ST_EOF      = 3'd4
    } tx_state_t;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } tx_beat_t;

endpackage

// File: rtl/fibre_bit_timer.sv
// Free-running line-bit counter; bstb_c marks the last clk_x8 cycle of every line bit.
module fibre_bit_timer
    import fibre_link_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE
) (
    input  logic clk_x8,
    input  logic rst,
    output logic bstb_c
);

    localparam int unsigned CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

    logic [CW-1:0] cnt;

    assign bstb_c = (cnt == CW'(OVERSAMPLE - 1));

    always_ff @(posedge clk_x8 or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (bstb_c) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/fibre_tx.sv
// Fibre line transmitter: alternating idle/preamble, sync byte, bit-stuffed payload and a ones EOF run.
module fibre_tx
    import fibre_link_pkg::*;
#(
    parameter int unsigned OVERSAMPLE    = DEF_OVERSAMPLE,
    parameter int unsigned PREAMBLE_BITS = DEF_PREAMBLE_BITS,
    parameter logic [7:0]  SYNC_BYTE     = DEF_SYNC_BYTE,
    parameter int unsigned MAX_RUN       = DEF_MAX_RUN,
    parameter int unsigned EOF_BITS      = DEF_EOF_BITS
) (
    input  logic       clk_x8,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       d_out,
    output logic       busy,
    output logic       underrun
);

    localparam int unsigned CNT_MAX = (PREAMBLE_BITS > EOF_BITS) ? PREAMBLE_BITS : EOF_BITS;
    localparam int unsigned CNT_W   = (CNT_MAX < 8) ? 4 : $clog2(CNT_MAX + 1);
    localparam int unsigned RUN_W   = $clog2(MAX_RUN + 1);

    tx_state_t         state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [7:0]        shreg, shreg_nx;
    logic [3:0]        bit_idx, bit_idx_nx;
    logic              cur_last, cur_last_nx;
    logic              run_val, run_val_nx;
    logic [RUN_W-1:0]  run_len, run_len_nx;
    logic              d_nx, underrun_nx;
    logic              load, emit, dbit;
    logic              bstb;
    logic              buf_full;
    tx_beat_t          buf_q;

    assign buf_full = !tx_ready;

    fibre_bit_timer #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_timer (
        .clk_x8 (clk_x8),
        .rst    (rst),
        .bstb_c (bstb)
    );

    // Next-state and line-bit selection; everything advances only on a bit boundary.
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        shreg_nx    = shreg;
        bit_idx_nx  = bit_idx;
        cur_last_nx = cur_last;
        run_val_nx  = run_val;
        run_len_nx  = run_len;
        d_nx        = d_out;
        underrun_nx = 1'b0;
        load        = 1'b0;
        emit        = 1'b0;
        dbit        = 1'b0;

        if (bstb) begin
            unique case (state)
                ST_IDLE: begin
                    d_nx = ~d_out;
                    if (buf_full) begin
                        state_nx = ST_PREAMBLE;
                        cnt_nx   = CNT_W'(1);
                    end
                end
                ST_PREAMBLE: begin
                    if (cnt == CNT_W'(PREAMBLE_BITS)) begin
                        state_nx = ST_SYNC;
                        d_nx     = SYNC_BYTE[0];
                        cnt_nx   = CNT_W'(1);
                    end else begin
                        d_nx   = ~d_out;
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
                ST_SYNC: begin
                    d_nx   = SYNC_BYTE[cnt[2:0]];
                    cnt_nx = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(7)) begin
                        state_nx   = ST_DATA;
                        load       = 1'b1;
                        run_len_nx = '0;
                    end
                end
                ST_DATA: begin
                    if (run_len == RUN_W'(MAX_RUN)) begin
                        // Stuffed complement; does not consume a payload bit.
                        d_nx       = ~run_val;
                        run_val_nx = ~run_val;
                        run_len_nx = RUN_W'(1);
                    end else if (bit_idx == 4'd8) begin
                        if (cur_last) begin
                            state_nx = ST_EOF;
                            d_nx     = 1'b1;
                            cnt_nx   = CNT_W'(1);
                        end else if (buf_full) begin
                            load = 1'b1;
                            emit = 1'b1;
                        end else begin
                            underrun_nx = 1'b1;
                            state_nx    = ST_EOF;
                            d_nx        = 1'b1;
                            cnt_nx      = CNT_W'(1);
                        end
                    end else begin
                        emit = 1'b1;
                    end
                end
                ST_EOF: begin
                    if (cnt == CNT_W'(EOF_BITS)) begin
                        state_nx = ST_IDLE;
                        d_nx     = 1'b0;
                    end else begin
                        d_nx   = 1'b1;
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_nx = ST_IDLE;
                end
            endcase
        end

        if (load) begin
            shreg_nx    = buf_q.data;
            cur_last_nx = buf_q.last;
            bit_idx_nx  = 4'd0;
        end

        // Emit one payload bit LSB first and extend or restart the run.
        if (emit) begin
            dbit       = shreg_nx[0];
            d_nx       = dbit;
            shreg_nx   = {1'b0, shreg_nx[7:1]};
            bit_idx_nx = bit_idx_nx + 4'd1;
            if ((run_len_nx != '0) && (dbit == run_val_nx)) begin
                run_len_nx = run_len_nx + RUN_W'(1);
            end else begin
                run_val_nx = dbit;
                run_len_nx = RUN_W'(1);
            end
        end
    end

    always_ff @(posedge clk_x8 or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            shreg    <= '0;
            bit_idx  <= '0;
            cur_last <= 1'b0;
            run_val  <= 1'b0;
            run_len  <= '0;
            d_out    <= 1'b0;
            busy     <= 1'b0;
            underrun <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            shreg    <= shreg_nx;
            bit_idx  <= bit_idx_nx;
            cur_last <= cur_last_nx;
            run_val  <= run_val_nx;
            run_len  <= run_len_nx;
            d_out    <= d_nx;
            busy     <= (state_nx != ST_IDLE);
            underrun <= underrun_nx;
        end
    end

    // Single-entry holding buffer; a load can only happen while it is full.
    always_ff @(posedge clk_x8 or posedge rst) begin
        if (rst) begin
            tx_ready <= 1'b1;
            buf_q    <= '0;
        end else if (load) begin
            tx_ready <= 1'b1;
        end else if (tx_valid && tx_ready) begin
            buf_q.data <= tx_data;
            buf_q.last <= tx_last;
            tx_ready   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fibre_tx.sv
// Self-checking bench for fibre_tx: mid-bit line capture compared against a frame-level reference model.
module tb_fibre_tx;

    logic       clk_x8   = 1'b0;
    logic       rst      = 1'b1;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_last  = 1'b0;
    logic       tx_ready, d_out, busy, underrun;

    int tests = 0;
    int fails = 0;

    fibre_tx dut (
        .clk_x8   (clk_x8),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_last  (tx_last),
        .tx_ready (tx_ready),
        .d_out    (d_out),
        .busy     (busy),
        .underrun (underrun)
    );

    always #5 clk_x8 = ~clk_x8;

    // Line monitor: bit phase from reset, mid-bit samples, edge placement and pulse counts.
    int unsigned ph = 0;
    logic        d_prev = 1'b0;
    int          glitch = 0;
    int          busy_cyc = 0;
    int          ur_cnt = 0;
    logic        bits_q[$];
    logic        busyb_q[$];

    always @(posedge clk_x8 or posedge rst) begin
        if (rst) ph <= 0;
        else     ph <= ph + 1;
    end

    always @(negedge clk_x8) begin
        d_prev <= d_out;
        if (!rst) begin
            if ((d_out !== d_prev) && ((ph % 8) != 0)) glitch <= glitch + 1;
            if ((ph % 8) == 4) begin
                bits_q.push_back(d_out);
                busyb_q.push_back(busy);
            end
            if (busy)     busy_cyc <= busy_cyc + 1;
            if (underrun) ur_cnt   <= ur_cnt + 1;
        end
    end

    logic [7:0] mb [0:3];
    logic       exp_q[$];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected frame line bits from the framing rules, given the idle bit preceding it.
    task automatic build_model(input int nb, input logic prev);
        logic       b;
        logic       rv;
        int         run;
        logic [7:0] sy;
        sy = 8'hD5;
        exp_q.delete();
        b = prev;
        for (int i = 0; i < 16; i++) begin
            b = ~b;
            exp_q.push_back(b);
        end
        for (int i = 0; i < 8; i++) exp_q.push_back(sy[i]);
        run = 0;
        rv  = 1'b0;
        for (int k = 0; k < nb; k++) begin
            for (int i = 0; i < 8; i++) begin
                b = mb[k][i];
                exp_q.push_back(b);
                if (run > 0 && b == rv) run++;
                else begin
                    rv  = b;
                    run = 1;
                end
                if (run == 5) begin
                    rv = ~rv;
                    exp_q.push_back(rv);
                    run = 1;
                end
            end
        end
        for (int i = 0; i < 8; i++) exp_q.push_back(1'b1);
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        @(negedge clk_x8);
        while (!tx_ready && n < 2000) begin
            @(negedge clk_x8);
            n++;
        end
        chk("send_ready", 256'(tx_ready), 256'(1));
        tx_valid = 1'b1;
        tx_data  = d;
        tx_last  = l;
        @(negedge clk_x8);
        tx_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!busy && n < 400) begin
            @(negedge clk_x8);
            n++;
        end
        chk({tag, "_start"}, 256'(busy), 256'(1));
        n = 0;
        while (busy && n < 4000) begin
            @(negedge clk_x8);
            n++;
        end
        chk({tag, "_end"}, 256'(busy), 256'(0));
        repeat (24) @(negedge clk_x8);
    endtask

    task automatic run_frame(input string tag, input int nb, input logic ur, input int exp_len);
        int           mark, b0, u0, fs, fe, n;
        logic [255:0] ov, ev;
        mark = bits_q.size();
        b0   = busy_cyc;
        u0   = ur_cnt;
        for (int k = 0; k < nb; k++) send(mb[k], (k == nb - 1) && !ur);
        wait_done(tag);
        fs = -1;
        for (int i = mark; i < bits_q.size(); i++) begin
            if (busyb_q[i]) begin
                fs = i;
                break;
            end
        end
        chk({tag, "_seen"}, 256'(fs > 0), 256'(1));
        if (fs <= 0) return;
        fe = fs;
        while (fe + 1 < bits_q.size() && busyb_q[fe + 1]) fe++;
        build_model(nb, bits_q[fs - 1]);
        n = fe - fs + 1;
        chk({tag, "_len"}, 256'(n), 256'(exp_q.size()));
        if (exp_len != 0) chk({tag, "_len_abs"}, 256'(n), 256'(exp_len));
        ov = '0;
        ev = '0;
        for (int i = 0; i < n && i < 256; i++) ov[i] = bits_q[fs + i];
        for (int i = 0; i < exp_q.size() && i < 256; i++) ev[i] = exp_q[i];
        chk({tag, "_bits"}, ov, ev);
        chk({tag, "_busy_cycles"}, 256'(busy_cyc - b0), 256'(8 * exp_q.size()));
        chk({tag, "_underrun"}, 256'(ur_cnt - u0), 256'(ur ? 1 : 0));
        if (fe + 2 < bits_q.size())
            chk({tag, "_idle_after"}, 256'({bits_q[fe + 2], bits_q[fe + 1]}), 256'(2'b10));
        else
            chk({tag, "_idle_after_len"}, 256'(bits_q.size()), 256'(fe + 3));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          mark, nb, u0;
        logic        ur;
        logic [255:0] ov, bv;

        repeat (3) @(negedge clk_x8);
        rst = 1'b0;
        @(negedge clk_x8);
        chk("rst_d_out",    256'(d_out),    256'(0));
        chk("rst_busy",     256'(busy),     256'(0));
        chk("rst_tx_ready", 256'(tx_ready), 256'(1));
        chk("rst_underrun", 256'(underrun), 256'(0));

        repeat (56) @(negedge clk_x8);
        ov = '0;
        bv = '0;
        for (int i = 0; i < 6; i++) begin
            ov[i] = bits_q[i];
            bv[i] = busyb_q[i];
        end
        chk("idle_toggle", ov, 256'(6'b101010));
        chk("idle_busy", bv, 256'(0));

        mb[0] = 8'hA5;
        run_frame("a5", 1, 1'b0, 40);
        mb[0] = 8'hFF; mb[1] = 8'hFF;
        run_frame("ff_ff", 2, 1'b0, 51);
        mb[0] = 8'hF8;
        run_frame("f8", 1, 1'b0, 41);
        mb[0] = 8'h3C;
        run_frame("underrun", 1, 1'b1, 40);
        chk("underrun_busy", 256'(busy), 256'(0));
        chk("underrun_ready", 256'(tx_ready), 256'(1));

        for (int t = 0; t < 8; t++) begin
            nb = int'($urandom_range(1, 4));
            for (int k = 0; k < 4; k++) mb[k] = 8'($urandom);
            ur = ($urandom_range(0, 3) == 0);
            run_frame("rand", nb, ur, 0);
        end

        // Reset in the middle of payload bits of a multi-byte frame.
        u0 = ur_cnt;
        send(8'h5A, 1'b0);
        send(8'h33, 1'b0);
        send(8'hC3, 1'b0);
        repeat (20) @(negedge clk_x8);
        chk("pre_rst_busy", 256'(busy), 256'(1));
        chk("pre_rst_ready", 256'(tx_ready), 256'(0));
        rst = 1'b1;
        #1;
        chk("mid_rst_d_out", 256'(d_out), 256'(0));
        chk("mid_rst_busy", 256'(busy), 256'(0));
        chk("mid_rst_ready", 256'(tx_ready), 256'(1));
        repeat (2) @(negedge clk_x8);
        rst = 1'b0;
        mark = bits_q.size();
        repeat (40) @(negedge clk_x8);
        ov = '0;
        bv = '0;
        for (int i = 0; i < 5 && mark + i < bits_q.size(); i++) begin
            ov[i] = bits_q[mark + i];
            bv[i] = busyb_q[mark + i];
        end
        chk("post_rst_count", 256'(bits_q.size() - mark), 256'(5));
        chk("post_rst_idle", ov, 256'(5'b01010));
        chk("post_rst_busy", bv, 256'(0));
        chk("post_rst_underrun", 256'(ur_cnt - u0), 256'(0));

        chk("bit_period", 256'(glitch), 256'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
